// File: rtl/idli_mem_arb_m_if.sv
// Core-side handshake between the fetch/LSU requesters and the SQI SRAM arbiter.
// The arbiter connects through the slave modport; requesters (or a bench) use master.
interface idli_mem_arb_m_if;
  logic        i_fet_req;
  logic [15:0] i_fet_addr;
  logic        o_fet_gnt;
  logic        o_fet_done;
  logic        i_lsu_req;
  logic        i_lsu_we;
  logic [15:0] i_lsu_addr;
  logic [15:0] i_lsu_wdata;
  logic        o_lsu_gnt;
  logic        o_lsu_done;
  logic [15:0] o_rdata;
  logic        o_busy;

  modport slave (
    input  i_fet_req, i_fet_addr, i_lsu_req, i_lsu_we, i_lsu_addr, i_lsu_wdata,
    output o_fet_gnt, o_fet_done, o_lsu_gnt, o_lsu_done, o_rdata, o_busy
  );

  modport master (
    output i_fet_req, i_fet_addr, i_lsu_req, i_lsu_we, i_lsu_addr, i_lsu_wdata,
    input  o_fet_gnt, o_fet_done, o_lsu_gnt, o_lsu_done, o_rdata, o_busy
  );
endinterface

// File: rtl/idli_mem_arb_m.sv
// Fetch/LSU arbiter and quad-SPI sequencer for the single SQI SRAM.
// Define IDLI_MEM_ARB_RR_EN for round-robin arbitration; default is lsu-over-fetch priority.
module idli_mem_arb_m #(
  parameter logic [7:0]  CMD_RD       = 8'h03,
  parameter logic [7:0]  CMD_WR       = 8'h02,
  parameter int unsigned RD_DUMMY_NIB = 2
) (
  input  logic               i_core_gck,
  input  logic               i_core_rst_n,
  idli_mem_arb_m_if.slave    io_bus,
  output logic               o_sqi_sck,
  output logic               o_sqi_cs,
  output logic               o_sqi_mode,
  output logic [3:0]         o_sqi_data,
  input  logic [3:0]         i_sqi_data
);

  typedef enum logic [2:0] {StIdle, StCmd, StAddr, StDummy, StData, StGap} state_e;

  state_e      r_state, w_state_nxt;
  logic        r_phase;
  logic [2:0]  r_nib;
  logic        r_own_lsu;
  logic        r_we;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic [11:0] r_rd_buf;
  logic [15:0] r_rdata;

  logic        w_any;
  logic        w_pick_lsu;
  logic        w_last;
  logic        w_end;
  logic [7:0]  w_cmd;
  logic [23:0] w_addr24;

  assign w_any    = io_bus.i_fet_req | io_bus.i_lsu_req;
  assign w_cmd    = r_we ? CMD_WR : CMD_RD;
  assign w_addr24 = {7'b0, r_addr, 1'b0};

`ifdef IDLI_MEM_ARB_RR_EN
  logic r_last_lsu;

  // On a tie the requester that did not own the previous transaction wins.
  assign w_pick_lsu = io_bus.i_lsu_req & (~io_bus.i_fet_req | ~r_last_lsu);

  always_ff @(posedge i_core_gck or negedge i_core_rst_n) begin
    if (!i_core_rst_n) begin
      r_last_lsu <= 1'b0;
    end else if (r_state == StIdle && w_any) begin
      r_last_lsu <= w_pick_lsu;
    end
  end
`else
  assign w_pick_lsu = io_bus.i_lsu_req;
`endif

  always_comb begin
    w_last = 1'b0;
    case (r_state)
      StCmd:   w_last = (r_nib == 3'd1);
      StAddr:  w_last = (r_nib == 3'd5);
      StDummy: w_last = (r_nib == 3'(RD_DUMMY_NIB - 1));
      StData:  w_last = (r_nib == 3'd3);
      StGap:   w_last = 1'b1;
      default: w_last = 1'b0;
    endcase
  end

  assign w_end = r_phase & w_last;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle:  if (w_any) w_state_nxt = StCmd;
      StCmd:   if (w_end) w_state_nxt = StAddr;
      StAddr:  if (w_end) w_state_nxt = (!r_we && RD_DUMMY_NIB != 0) ? StDummy : StData;
      StDummy: if (w_end) w_state_nxt = StData;
      StData:  if (w_end) w_state_nxt = StGap;
      StGap:   if (w_end) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_core_gck or negedge i_core_rst_n) begin
    if (!i_core_rst_n) begin
      r_state <= StIdle;
      r_phase <= 1'b0;
      r_nib   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == StIdle) begin
        r_phase <= 1'b0;
        r_nib   <= 3'd0;
      end else begin
        r_phase <= ~r_phase;
        if (w_end) begin
          r_nib <= 3'd0;
        end else if (r_phase) begin
          r_nib <= r_nib + 3'd1;
        end
      end
    end
  end

  // Fetch never writes, whatever the LSU write-enable happens to be.
  always_ff @(posedge i_core_gck or negedge i_core_rst_n) begin
    if (!i_core_rst_n) begin
      r_own_lsu <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= 16'h0;
      r_wdata   <= 16'h0;
    end else if (r_state == StIdle && w_any) begin
      r_own_lsu <= w_pick_lsu;
      r_we      <= w_pick_lsu & io_bus.i_lsu_we;
      r_addr    <= w_pick_lsu ? io_bus.i_lsu_addr : io_bus.i_fet_addr;
      r_wdata   <= io_bus.i_lsu_wdata;
    end
  end

  always_ff @(posedge i_core_gck or negedge i_core_rst_n) begin
    if (!i_core_rst_n) begin
      r_rd_buf <= 12'h0;
      r_rdata  <= 16'h0;
    end else if (r_state == StData && r_phase && !r_we) begin
      case (r_nib[1:0])
        2'd0:    r_rd_buf[3:0]  <= i_sqi_data;
        2'd1:    r_rd_buf[7:4]  <= i_sqi_data;
        2'd2:    r_rd_buf[11:8] <= i_sqi_data;
        default: r_rdata        <= {i_sqi_data, r_rd_buf};
      endcase
    end
  end

  always_comb begin
    o_sqi_cs   = 1'b1;
    o_sqi_sck  = 1'b0;
    o_sqi_mode = 1'b1;
    o_sqi_data = 4'h0;
    case (r_state)
      StCmd: begin
        o_sqi_cs   = 1'b0;
        o_sqi_sck  = r_phase;
        o_sqi_data = r_nib[0] ? w_cmd[3:0] : w_cmd[7:4];
      end
      StAddr: begin
        o_sqi_cs  = 1'b0;
        o_sqi_sck = r_phase;
        case (r_nib)
          3'd0:    o_sqi_data = w_addr24[23:20];
          3'd1:    o_sqi_data = w_addr24[19:16];
          3'd2:    o_sqi_data = w_addr24[15:12];
          3'd3:    o_sqi_data = w_addr24[11:8];
          3'd4:    o_sqi_data = w_addr24[7:4];
          default: o_sqi_data = w_addr24[3:0];
        endcase
      end
      StDummy: begin
        o_sqi_cs   = 1'b0;
        o_sqi_sck  = r_phase;
        o_sqi_mode = 1'b0;
      end
      StData: begin
        o_sqi_cs  = 1'b0;
        o_sqi_sck = r_phase;
        if (r_we) begin
          case (r_nib[1:0])
            2'd0:    o_sqi_data = r_wdata[3:0];
            2'd1:    o_sqi_data = r_wdata[7:4];
            2'd2:    o_sqi_data = r_wdata[11:8];
            default: o_sqi_data = r_wdata[15:12];
          endcase
        end else begin
          o_sqi_mode = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign io_bus.o_fet_gnt  = (r_state == StIdle) & w_any & ~w_pick_lsu;
  assign io_bus.o_lsu_gnt  = (r_state == StIdle) & w_pick_lsu;
  assign io_bus.o_fet_done = (r_state == StGap) & ~r_phase & ~r_own_lsu;
  assign io_bus.o_lsu_done = (r_state == StGap) & ~r_phase & r_own_lsu;
  assign io_bus.o_rdata    = r_rdata;
  assign io_bus.o_busy     = (r_state != StIdle);

endmodule

// File: tb/tb_idli_mem_arb_m.sv
// Scoreboard bench for idli_mem_arb_m with a behavioural SQI SRAM model on the pins.
module tb_idli_mem_arb_m;

  typedef struct {
    bit          lsu;
    bit          we;
    logic [15:0] rdata;
    logic [47:0] bus;
    int          nbus;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sck, cs, mode;
  logic [3:0] sqo;
  logic [3:0] sqi = 4'h0;

  idli_mem_arb_m_if bus ();

  idli_mem_arb_m dut (
    .i_core_gck   (clk),
    .i_core_rst_n (rst_n),
    .io_bus       (bus),
    .o_sqi_sck    (sck),
    .o_sqi_cs     (cs),
    .o_sqi_mode   (mode),
    .o_sqi_data   (sqo),
    .i_sqi_data   (sqi)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  exp_t        sb_q[$];
  logic [15:0] ref_mem[int];
  logic [15:0] sram[int];
  logic [15:0] rdata_ref = 16'h0;
  bit          last_lsu = 1'b0;
  bit          b2b_mode = 1'b0;

  function automatic bit first_is_lsu();
`ifdef IDLI_MEM_ARB_RR_EN
    return !last_lsu;
`else
    return 1'b1;
`endif
  endfunction

  task automatic issue(input bit lsu, input bit we, input logic [15:0] addr,
                       input logic [15:0] wdata);
    exp_t        e;
    logic [23:0] a;
    a     = {7'b0, addr, 1'b0};
    e.lsu = lsu;
    e.we  = we;
    if (we) begin
      e.bus   = {8'h02, a, wdata[3:0], wdata[7:4], wdata[11:8], wdata[15:12]};
      e.nbus  = 12;
      e.rdata = 16'h0;
      ref_mem[int'(a)] = wdata;
    end else begin
      e.bus   = {16'h0, 8'h03, a};
      e.nbus  = 8;
      e.rdata = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 16'h0;
    end
    sb_q.push_back(e);
    last_lsu = lsu;
    if (lsu) begin
      bus.i_lsu_req   = 1'b1;
      bus.i_lsu_we    = we;
      bus.i_lsu_addr  = addr;
      bus.i_lsu_wdata = wdata;
    end else begin
      bus.i_fet_req  = 1'b1;
      bus.i_fet_addr = addr;
    end
  endtask

  task automatic wait_gnt(input int budget);
    int n = 0;
    bit seen = 1'b0;
    bit gl = 1'b0;
    bit gf = 1'b0;
    while (!seen && n < budget) begin
      @(negedge clk);
      if (bus.o_fet_gnt || bus.o_lsu_gnt) begin
        seen = 1'b1;
        gl   = bus.o_lsu_gnt;
        gf   = bus.o_fet_gnt;
      end
      n++;
    end
    check_eq("gnt_timeout", 64'(seen), 64'd1);
    @(posedge clk);
    #1;
    if (gl) bus.i_lsu_req = 1'b0;
    if (gf) bus.i_fet_req = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    bit gl, gf;
    while ((bus.i_fet_req || bus.i_lsu_req || sb_q.size() != 0) && n < budget) begin
      @(negedge clk);
      gl = bus.o_lsu_gnt;
      gf = bus.o_fet_gnt;
      @(posedge clk);
      #1;
      if (gl) bus.i_lsu_req = 1'b0;
      if (gf) bus.i_fet_req = 1'b0;
      n++;
    end
    check_eq("drain_pending", 64'(sb_q.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Pin-level SRAM model, bookkeeping and scoreboard, all sampled mid-cycle.
  int          cyc = 0;
  int          k = 0;
  int          j;
  int          gl_cyc = 0;
  int          gf_cyc = 0;
  int          done_cyc = 0;
  int          cs_hi = 0;
  int          cap_n = 0;
  int          cap_m0 = 0;
  bit          pend_gap = 1'b0;
  bit          pend_cs = 1'b0;
  logic [47:0] cap_bus = 48'h0;
  logic [31:0] hdr = 32'h0;
  logic [15:0] wbuf = 16'h0;
  logic [15:0] word;
  exp_t        e;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      k        = 0;
      cs_hi    = 0;
      pend_gap = 1'b0;
      pend_cs  = 1'b0;
      sqi      = 4'h0;
    end else begin
      if (bus.o_fet_gnt || bus.o_lsu_gnt) begin
        check_eq("gnt_onehot", 64'(bus.o_fet_gnt & bus.o_lsu_gnt), 64'd0);
        if (bus.o_lsu_gnt) gl_cyc = cyc;
        else gf_cyc = cyc;
        if (pend_gap) begin
          check_eq("gnt_after_done", 64'(cyc - done_cyc), 64'd2);
          pend_gap = 1'b0;
        end
      end

      if (bus.o_fet_done || bus.o_lsu_done) begin
        if (sb_q.size() == 0) begin
          check_eq("spurious_done", {62'h0, bus.o_lsu_done, bus.o_fet_done}, 64'd0);
        end else begin
          e = sb_q.pop_front();
          check_eq("done_owner", {62'h0, bus.o_lsu_done, bus.o_fet_done},
                   e.lsu ? 64'd2 : 64'd1);
          check_eq("latency", 64'(cyc - (e.lsu ? gl_cyc : gf_cyc)), e.we ? 64'd25 : 64'd29);
          check_eq("bus_nibbles", 64'(cap_bus), 64'(e.bus));
          check_eq("bus_count", 64'(cap_n), 64'(e.nbus));
          check_eq("mode0_count", 64'(cap_m0), e.we ? 64'd0 : 64'd6);
          check_eq("done_busy", 64'(bus.o_busy), 64'd1);
          if (!e.we) rdata_ref = e.rdata;
          check_eq("done_rdata", 64'(bus.o_rdata), 64'(rdata_ref));
        end
        done_cyc = cyc;
        if (b2b_mode && (bus.i_fet_req || bus.i_lsu_req)) begin
          pend_gap = 1'b1;
          pend_cs  = 1'b1;
        end
      end else if (bus.o_busy) begin
        check_eq("rdata_hold", 64'(bus.o_rdata), 64'(rdata_ref));
      end

      if (cs) begin
        cs_hi++;
        k = 0;
      end else begin
        // Between back-to-back transfers cs stays high for GAP (2) plus the arbitration cycle.
        if (pend_cs) begin
          check_eq("cs_high_run", 64'(cs_hi), 64'd3);
          pend_cs = 1'b0;
        end
        cs_hi = 0;
        if (sck) begin
          if (k == 0) begin
            cap_bus = 48'h0;
            cap_n   = 0;
            cap_m0  = 0;
            hdr     = 32'h0;
          end
          if (mode) begin
            cap_bus = {cap_bus[43:0], sqo};
            cap_n++;
          end else begin
            cap_m0++;
          end
          if (k < 8) begin
            hdr = {hdr[27:0], sqo};
          end else if (hdr[31:24] == 8'h02) begin
            wbuf[4*(k-8) +: 4] = sqo;
            if (k == 11) sram[int'(hdr[23:0])] = wbuf;
          end else begin
            j    = k - 8;
            word = sram.exists(int'(hdr[23:0])) ? sram[int'(hdr[23:0])] : 16'h0;
            sqi  = (j >= 2 && j < 6) ? word[4*(j-2) +: 4] : 4'h0;
          end
          k++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_fet_req   = 1'b0;
    bus.i_fet_addr  = 16'h0;
    bus.i_lsu_req   = 1'b0;
    bus.i_lsu_we    = 1'b0;
    bus.i_lsu_addr  = 16'h0;
    bus.i_lsu_wdata = 16'h0;
    sram[int'(24'h000024)]    = 16'hC3A5;
    ref_mem[int'(24'h000024)] = 16'hC3A5;
    sram[int'(24'h000200)]    = 16'h9E71;
    ref_mem[int'(24'h000200)] = 16'h9E71;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_cs", 64'(cs), 64'd1);
    check_eq("rst_sck", 64'(sck), 64'd0);
    check_eq("rst_mode", 64'(mode), 64'd1);
    check_eq("rst_data", 64'(sqo), 64'd0);
    check_eq("rst_gnt", {62'h0, bus.o_fet_gnt, bus.o_lsu_gnt}, 64'd0);
    check_eq("rst_done", {62'h0, bus.o_fet_done, bus.o_lsu_done}, 64'd0);
    check_eq("rst_busy", 64'(bus.o_busy), 64'd0);
    check_eq("rst_rdata", 64'(bus.o_rdata), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Fetch read with a stray LSU write-enable that must be ignored.
    bus.i_lsu_we = 1'b1;
    issue(1'b0, 1'b0, 16'h0012, 16'h0);
    wait_drain(100);

    issue(1'b1, 1'b1, 16'h8001, 16'h1234);
    wait_drain(100);

    b2b_mode = 1'b1;
    if (first_is_lsu()) begin
      issue(1'b1, 1'b0, 16'h8001, 16'h0);
      issue(1'b0, 1'b0, 16'h0012, 16'h0);
    end else begin
      issue(1'b0, 1'b0, 16'h0012, 16'h0);
      issue(1'b1, 1'b0, 16'h8001, 16'h0);
    end
    wait_drain(200);

    issue(1'b1, 1'b0, 16'h0100, 16'h0);
    wait_gnt(20);
    repeat (3) @(posedge clk);
    #1;
    issue(1'b1, 1'b0, 16'h8001, 16'h0);
    wait_drain(200);
    b2b_mode = 1'b0;

    // Abort a fetch partway through the address nibbles.
    bus.i_fet_req  = 1'b1;
    bus.i_fet_addr = 16'h0012;
    wait_gnt(20);
    repeat (5) @(posedge clk);
    #3;
    check_eq("pre_rst_sck", 64'(sck), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_cs", 64'(cs), 64'd1);
    check_eq("async_rst_sck", 64'(sck), 64'd0);
    check_eq("async_rst_busy", 64'(bus.o_busy), 64'd0);
    rdata_ref = 16'h0;
    last_lsu  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check_eq("abort_no_done", 64'(sb_q.size()), 64'd0);

    issue(1'b0, 1'b0, 16'h0012, 16'h0);
    wait_drain(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
